// File: rtl/mips_pkg.sv
// Shared constants and run-control state encodings for the MIPS pipeline stages.
package mips_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one registered write port, one combinational read port.
module instruction_memory #(
  parameter int NB_DATA      = 32,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [NB_IMEM_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0]      wdata,
  input  logic [NB_IMEM_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0]      rdata
);

  logic [NB_DATA-1:0] mem [2**NB_IMEM_ADDR];

  // Contents survive reset; only the loader changes them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, instruction memory, IF/ID register and the IDLE/RUN/HALTED run control.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_clear,
  input  logic                    i_halt,
  input  logic                    i_stall,
  input  logic                    i_jump,
  input  logic [NB_DATA-1:0]      i_addr2jump,
  input  logic                    i_inst_we,
  input  logic [NB_IMEM_ADDR-1:0] i_inst_waddr,
  input  logic [NB_DATA-1:0]      i_inst_wdata,
  output logic [NB_DATA-1:0]      o_instruction,
  output logic [NB_DATA-1:0]      o_pcounter4,
  output logic [NB_DATA-1:0]      o_pc,
  output logic [1:0]              o_state,
  output logic                    o_halted
);

  localparam logic [NB_DATA-1:0] HALT = NB_DATA'(HALT_WORD);
  localparam logic [NB_DATA-1:0] NOP  = NB_DATA'(NOP_WORD);
  localparam logic [NB_DATA-1:0] FOUR = NB_DATA'(4);

  fetch_state_t       state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] inst_q, inst_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic [NB_DATA-1:0] mem_rdata;
  logic [NB_DATA-1:0] pc_plus4;
  logic               mem_we;

  // i_halt freezes every piece of state, the loader port included.
  assign mem_we = i_inst_we && (state_q == ST_IDLE) && !i_halt;

  instruction_memory #(
    .NB_DATA      (NB_DATA),
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (i_inst_waddr),
    .wdata (i_inst_wdata),
    .raddr (pc_q[NB_IMEM_ADDR+1:2]),
    .rdata (mem_rdata)
  );

  assign pc_plus4 = pc_q + FOUR;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_halt && i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_halt || i_stall) begin
          // Stall drops any jump: ID re-evaluates the held instruction next cycle.
        end else if (i_jump) begin
          pc_d   = i_addr2jump;
          inst_d = NOP;
          pc4_d  = '0;
        end else begin
          inst_d = mem_rdata;
          pc4_d  = pc_plus4;
          if (mem_rdata == HALT) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALTED: begin
        if (!i_halt && i_clear) begin
          state_d = ST_IDLE;
          pc_d    = '0;
          inst_d  = NOP;
          pc4_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      inst_q  <= NOP;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

  assign o_instruction = inst_q;
  assign o_pcounter4   = pc4_q;
  assign o_pc          = pc_q;
  assign o_state       = state_q;
  assign o_halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch with a few hand-written multi-cycle sequences.
module tb_instruction_fetch;

  localparam int NB_DATA      = 32;
  localparam int NB_IMEM_ADDR = 8;
  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_R = 2'b01;
  localparam logic [1:0] S_H = 2'b10;

  logic                    clk;
  logic                    i_rst;
  logic                    i_start;
  logic                    i_clear;
  logic                    i_halt;
  logic                    i_stall;
  logic                    i_jump;
  logic [NB_DATA-1:0]      i_addr2jump;
  logic                    i_inst_we;
  logic [NB_IMEM_ADDR-1:0] i_inst_waddr;
  logic [NB_DATA-1:0]      i_inst_wdata;
  logic [NB_DATA-1:0]      o_instruction;
  logic [NB_DATA-1:0]      o_pcounter4;
  logic [NB_DATA-1:0]      o_pc;
  logic [1:0]              o_state;
  logic                    o_halted;

  instruction_fetch #(
    .NB_DATA      (NB_DATA),
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_clear       (i_clear),
    .i_halt        (i_halt),
    .i_stall       (i_stall),
    .i_jump        (i_jump),
    .i_addr2jump   (i_addr2jump),
    .i_inst_we     (i_inst_we),
    .i_inst_waddr  (i_inst_waddr),
    .i_inst_wdata  (i_inst_wdata),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_pc          (o_pc),
    .o_state       (o_state),
    .o_halted      (o_halted)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, clear, halt, stall, jump;
    logic [31:0] a2j;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_inst, e_pc4, e_pc;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rst, start, clear, halt, stall, jump,
                              input logic [31:0] a2j, input logic we,
                              input logic [7:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] e_inst, e_pc4, e_pc,
                              input logic [1:0] e_st);
    vec_t v;
    v.rst = rst; v.start = start; v.clear = clear; v.halt = halt;
    v.stall = stall; v.jump = jump; v.a2j = a2j; v.we = we;
    v.waddr = waddr; v.wdata = wdata;
    v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_pc = e_pc; v.e_st = e_st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input vec_t v);
    i_rst = v.rst; i_start = v.start; i_clear = v.clear; i_halt = v.halt;
    i_stall = v.stall; i_jump = v.jump; i_addr2jump = v.a2j;
    i_inst_we = v.we; i_inst_waddr = v.waddr; i_inst_wdata = v.wdata;
  endtask

  task automatic idle_inputs();
    i_rst = 0; i_start = 0; i_clear = 0; i_halt = 0; i_stall = 0; i_jump = 0;
    i_addr2jump = '0; i_inst_we = 0; i_inst_waddr = '0; i_inst_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int row, input logic [31:0] e_inst, e_pc4, e_pc,
                           input logic [1:0] e_st);
    chk("instruction", row, o_instruction, e_inst);
    chk("pcounter4", row, o_pcounter4, e_pc4);
    chk("pc", row, o_pc, e_pc);
    chk("state", row, {30'b0, o_state}, {30'b0, e_st});
    chk("halted", row, {31'b0, o_halted}, {31'b0, (e_st == S_H)});
  endtask

  initial begin
    bit seen;
    idle_inputs();
    //  rst st cl ha sl jp a2j           we idx    wdata          inst           pc4           pc            st
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd0,  32'h20010005,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd1,  32'h20020007,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd2,  32'hFFFFFFFF,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20010005,  32'h4,        32'h4,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20020007,  32'h8,        32'h8,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'hFFFFFFFF,  32'hC,        32'h8,        S_H);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'hFFFFFFFF,  32'hC,        32'h8,        S_H);
    add(0, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'hFFFFFFFF,  32'hC,        32'h8,        S_H);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd3,  32'h11111111,  32'hFFFFFFFF,  32'hC,        32'h8,        S_H);
    add(0, 0, 1, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd3,  32'h44444444,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd2,  32'h33333333,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd16, 32'h16161616,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd17, 32'h17171717,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd18, 32'hFFFFFFFF,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20010005,  32'h4,        32'h4,        S_R);
    add(0, 0, 0, 0, 0, 1, 32'h40,        0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h40,       S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h16161616,  32'h44,       32'h44,       S_R);
    add(0, 0, 0, 0, 1, 1, 32'h8,         0, 8'd0,  32'h0,         32'h16161616,  32'h44,       32'h44,       S_R);
    add(0, 0, 0, 0, 1, 1, 32'h8,         0, 8'd0,  32'h0,         32'h16161616,  32'h44,       32'h44,       S_R);
    add(0, 0, 0, 0, 0, 1, 32'h8,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h8,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h33333333,  32'hC,        32'hC,        S_R);
    add(0, 0, 0, 1, 0, 0, 32'h0,         1, 8'd3,  32'h55555555,  32'h33333333,  32'hC,        32'hC,        S_R);
    add(0, 0, 0, 1, 0, 0, 32'h0,         1, 8'd3,  32'h55555555,  32'h33333333,  32'hC,        32'hC,        S_R);
    add(0, 0, 0, 1, 0, 1, 32'h80,        1, 8'd3,  32'h55555555,  32'h33333333,  32'hC,        32'hC,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h44444444,  32'h10,       32'h10,       S_R);
    add(0, 0, 0, 0, 0, 1, 32'h44,        0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h44,       S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h17171717,  32'h48,       32'h48,       S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'hFFFFFFFF,  32'h4C,       32'h48,       S_H);
    add(0, 0, 1, 1, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'hFFFFFFFF,  32'h4C,       32'h48,       S_H);
    add(0, 0, 1, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd8,  32'h88888888,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_R);
    add(0, 0, 0, 0, 0, 1, 32'h20,        0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h20,       S_R);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_I);
    add(0, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20010005,  32'h4,        32'h4,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20020007,  32'h8,        32'h8,        S_R);
    add(1, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_I);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 8'd255,32'hABCD0001,  32'h0,         32'h0,        32'h0,        S_I);
    add(0, 1, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h0,        S_R);
    add(0, 0, 0, 0, 0, 1, 32'hFFFFFFFE,  0, 8'd0,  32'h0,         32'h0,         32'h0,        32'hFFFFFFFE, S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'hABCD0001,  32'h2,        32'h2,        S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20010005,  32'h6,        32'h6,        S_R);
    add(0, 0, 0, 0, 0, 1, 32'h404,       0, 8'd0,  32'h0,         32'h0,         32'h0,        32'h404,      S_R);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h20020007,  32'h408,      32'h408,      S_R);
    add(0, 0, 1, 0, 0, 0, 32'h0,         0, 8'd0,  32'h0,         32'h33333333,  32'h40C,      32'h40C,      S_R);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check_all(i, vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_pc, vecs[i].e_st);
    end

    // Redirect onto the HALT word at idx 18 and wait, bounded, for HALTED.
    idle_inputs();
    i_jump = 1; i_addr2jump = 32'h48;
    step();
    check_all(1000, 32'h0, 32'h0, 32'h48, S_R);
    idle_inputs();
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = o_halted;
    end
    chk("halt_reached", 1001, {31'b0, seen}, 32'h1);
    check_all(1002, 32'hFFFFFFFF, 32'h4C, 32'h48, S_H);

    // HALTED must hold through stray start/jump/stall/loader activity.
    for (int c = 0; c < 3; c++) begin
      i_start = 1'($urandom_range(0, 1));
      i_jump = 1; i_addr2jump = 32'h100;
      i_stall = 1'($urandom_range(0, 1));
      i_inst_we = 1; i_inst_waddr = 8'd18; i_inst_wdata = 32'h0;
      step();
      check_all(1003 + c, 32'hFFFFFFFF, 32'h4C, 32'h48, S_H);
    end

    // Loader write above was ignored: clear, rerun from 18 and halt again.
    idle_inputs();
    i_clear = 1;
    step();
    check_all(1010, 32'h0, 32'h0, 32'h0, S_I);
    idle_inputs();
    i_start = 1;
    step();
    idle_inputs();
    i_jump = 1; i_addr2jump = 32'h48;
    step();
    idle_inputs();
    step();
    check_all(1011, 32'hFFFFFFFF, 32'h4C, 32'h48, S_H);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
